// File: rtl/game_pkg.sv
// game_pkg: shared types and default constants for the game controller
// and the blocks that sit around it.
//   state_t             - game state encoding (IDLE, PLAYING, DYING, OVER)
//   *_FRAMES_DEF        - default frame-tick counts for flap, burn and score
//   SCORE_W             - width of the survival score
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DYING   = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int FLAP_FRAMES_DEF  = 8;
    localparam int BURN_FRAMES_DEF  = 60;
    localparam int SCORE_FRAMES_DEF = 30;
    localparam int SCORE_W          = 16;

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: signals between the game controller and its surroundings.
//   frame_clk  - VGA vertical sync (asynchronous to the system clock)
//   crash      - per-pixel collision flag from the colour mapper
//   start_key  - level, high while the start key is held
//   alternator - wing-flap sprite select
//   burn       - burning-sprite select
//   freeze     - hold bird and obstacle positions
//   game_over  - high in OVER
//   score      - unsigned survival score
//   frame_tick - one-cycle pulse per frame
// master: the environment (VGA timing, keyboard, colour mapper side).
// slave:  the game controller.
interface game_ctrl_if;
    import game_pkg::*;

    logic               frame_clk;
    logic               crash;
    logic               start_key;
    logic               alternator;
    logic               burn;
    logic               freeze;
    logic               game_over;
    logic [SCORE_W-1:0] score;
    logic               frame_tick;

    modport master (
        output frame_clk, crash, start_key,
        input  alternator, burn, freeze, game_over, score, frame_tick
    );

    modport slave (
        input  frame_clk, crash, start_key,
        output alternator, burn, freeze, game_over, score, frame_tick
    );

endinterface

// File: rtl/frame_sync.sv
// frame_sync: brings an asynchronous level (VGA vsync) into the clk domain
// and emits a single-cycle pulse for each of its rising edges.
//   clk   - destination clock
//   rst   - asynchronous active-high reset
//   level - asynchronous input
//   pulse - registered one-cycle pulse, 3 clk edges after a rising edge of level
module frame_sync (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= level;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame-rate game controller. Turns the colour mapper's crash
// flag into game state, drives the sprite selects, freezes motion after a
// crash and keeps a saturating survival score.
//   Clk   - system clock
//   Reset - asynchronous active-high reset
//   bus   - game_ctrl_if slave modport (inputs frame_clk, crash, start_key;
//           outputs alternator, burn, freeze, game_over, score, frame_tick)
module game_ctrl
    import game_pkg::*;
#(
    parameter int FLAP_FRAMES  = FLAP_FRAMES_DEF,
    parameter int BURN_FRAMES  = BURN_FRAMES_DEF,
    parameter int SCORE_FRAMES = SCORE_FRAMES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    game_ctrl_if.slave  bus
);

    localparam int FLAP_W = $clog2(FLAP_FRAMES + 1);
    localparam int BURN_W = $clog2(BURN_FRAMES + 1);
    localparam int DIV_W  = $clog2(SCORE_FRAMES + 1);

    localparam logic [FLAP_W-1:0] FLAP_LAST  = FLAP_W'(FLAP_FRAMES - 1);
    localparam logic [BURN_W-1:0] BURN_LAST  = BURN_W'(BURN_FRAMES - 1);
    localparam logic [DIV_W-1:0]  SCORE_LAST = DIV_W'(SCORE_FRAMES - 1);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (&v)
            return v;
        return v + 1'b1;
    endfunction

    state_t             state;
    logic [FLAP_W-1:0]  flap_cnt;
    logic [BURN_W-1:0]  burn_cnt;
    logic [DIV_W-1:0]   score_div;
    logic [SCORE_W-1:0] score_q;
    logic               crash_pending;
    logic               alternator_q;
    logic               burn_q;
    logic               freeze_q;
    logic               game_over_q;
    logic               start_d;
    logic               start_prev;
    logic               press;
    logic               frame_tick;

    frame_sync u_frame_sync (
        .clk   (Clk),
        .rst   (Reset),
        .level (bus.frame_clk),
        .pulse (frame_tick)
    );

    // start_d is the registered key level, so a press is seen one cycle
    // after the key rises and a held key yields only one press.
    assign press = start_d & ~start_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            flap_cnt      <= '0;
            burn_cnt      <= '0;
            score_div     <= '0;
            score_q       <= '0;
            crash_pending <= 1'b0;
            alternator_q  <= 1'b0;
            burn_q        <= 1'b0;
            freeze_q      <= 1'b1;
            game_over_q   <= 1'b0;
            start_d       <= 1'b0;
            start_prev    <= 1'b0;
        end else begin
            start_d    <= bus.start_key;
            start_prev <= start_d;

            // Wing flap animates while alive or waiting; holds once burning.
            if (frame_tick && (state == IDLE || state == PLAYING)) begin
                if (flap_cnt == FLAP_LAST) begin
                    flap_cnt     <= '0;
                    alternator_q <= ~alternator_q;
                end else begin
                    flap_cnt <= flap_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (press) begin
                        state         <= PLAYING;
                        freeze_q      <= 1'b0;
                        score_q       <= '0;
                        score_div     <= '0;
                        crash_pending <= 1'b0;
                    end
                end

                PLAYING: begin
                    if (frame_tick) begin
                        crash_pending <= 1'b0;
                        // A crash landing on the tick cycle itself still counts.
                        if (crash_pending | bus.crash) begin
                            state    <= DYING;
                            burn_q   <= 1'b1;
                            freeze_q <= 1'b1;
                            burn_cnt <= '0;
                        end else if (score_div == SCORE_LAST) begin
                            score_div <= '0;
                            score_q   <= sat_inc(score_q);
                        end else begin
                            score_div <= score_div + 1'b1;
                        end
                    end else if (bus.crash) begin
                        crash_pending <= 1'b1;
                    end
                end

                DYING: begin
                    if (frame_tick) begin
                        burn_cnt <= burn_cnt + 1'b1;
                        if (burn_cnt == BURN_LAST) begin
                            state       <= OVER;
                            game_over_q <= 1'b1;
                        end
                    end
                end

                OVER: begin
                    if (press) begin
                        state       <= IDLE;
                        burn_q      <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alternator = alternator_q;
    assign bus.burn       = burn_q;
    assign bus.freeze     = freeze_q;
    assign bus.game_over  = game_over_q;
    assign bus.score      = score_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed testbench for game_ctrl with default parameters
// (FLAP_FRAMES=8, BURN_FRAMES=60, SCORE_FRAMES=30).
module tb_game_ctrl;

    logic clk;
    logic rst;

    game_ctrl_if bus ();

    game_ctrl dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total;
    int bad;
    int tick_cnt;
    int dbl_cnt;
    int alt_tog;
    int rise_cnt;
    logic tick_prev;
    logic alt_prev;

    initial begin
        tick_cnt  = 0;
        dbl_cnt   = 0;
        alt_tog   = 0;
        tick_prev = 1'b0;
        alt_prev  = 1'b0;
    end

    // Observe frame_tick pulses and alternator toggles away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) begin
            tick_cnt = tick_cnt + 1;
            if (tick_prev)
                dbl_cnt = dbl_cnt + 1;
        end
        tick_prev = (bus.frame_tick === 1'b1);
        if (bus.alternator !== alt_prev)
            alt_tog = alt_tog + 1;
        alt_prev = bus.alternator;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // n vsync periods of 80 ns (4 clocks), edges placed away from clk edges.
    task automatic frames(input int n);
        @(negedge clk);
        #3;
        for (int i = 0; i < n; i++) begin
            rise_cnt     = rise_cnt + 1;
            bus.frame_clk = 1'b1;
            #33;
            bus.frame_clk = 1'b0;
            #47;
        end
        repeat (5) @(negedge clk);
    endtask

    // One vsync edge with a single-cycle crash placed on the frame_tick cycle.
    task automatic tick_with_crash();
        @(negedge clk);
        #3;
        rise_cnt      = rise_cnt + 1;
        bus.frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("tick_align", {31'd0, bus.frame_tick}, 32'd1);
        bus.crash = 1'b1;
        @(posedge clk);
        #1;
        bus.crash     = 1'b0;
        bus.frame_clk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk);
        bus.start_key = 1'b1;
        repeat (3) @(negedge clk);
        bus.start_key = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        rise_cnt      = 0;
        rst           = 1'b1;
        bus.frame_clk = 1'b0;
        bus.crash     = 1'b0;
        bus.start_key = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_alt",    {31'd0, bus.alternator}, 32'd0);
        check("rst_burn",   {31'd0, bus.burn},       32'd0);
        check("rst_freeze", {31'd0, bus.freeze},     32'd1);
        check("rst_over",   {31'd0, bus.game_over},  32'd0);
        check("rst_score",  {16'd0, bus.score},      32'd0);
        check("rst_tick",   {31'd0, bus.frame_tick}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Start and score
        press_start();
        check("start_freeze", {31'd0, bus.freeze}, 32'd0);
        check("start_burn",   {31'd0, bus.burn},   32'd0);
        begin
            int alt0;
            alt0 = alt_tog;
            frames(90);
            check("score_90",    {16'd0, bus.score}, 32'd3);
            check("alt_toggles", alt_tog - alt0,     32'd11);
            check("play_freeze", {31'd0, bus.freeze}, 32'd0);
        end

        // Crash latched mid-frame
        @(negedge clk);
        bus.crash = 1'b1;
        @(negedge clk);
        bus.crash = 1'b0;
        repeat (2) @(negedge clk);
        check("pend_freeze", {31'd0, bus.freeze}, 32'd0);
        check("pend_burn",   {31'd0, bus.burn},   32'd0);
        frames(1);
        check("dying_burn",   {31'd0, bus.burn},   32'd1);
        check("dying_freeze", {31'd0, bus.freeze}, 32'd1);
        check("dying_score",  {16'd0, bus.score},  32'd3);

        // Burn timing
        frames(59);
        check("burn59_over", {31'd0, bus.game_over}, 32'd0);
        frames(1);
        check("burn60_over", {31'd0, bus.game_over}, 32'd1);
        check("over_burn",   {31'd0, bus.burn},      32'd1);
        check("over_score",  {16'd0, bus.score},     32'd3);
        check("over_alt",    {31'd0, bus.alternator}, 32'd1);

        // Start press in OVER with the key held: back to IDLE, no auto-start
        @(negedge clk);
        bus.start_key = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_over",   {31'd0, bus.game_over}, 32'd0);
        check("idle_burn",   {31'd0, bus.burn},      32'd0);
        check("idle_freeze", {31'd0, bus.freeze},    32'd1);
        frames(2);
        check("held_freeze", {31'd0, bus.freeze}, 32'd1);
        bus.start_key = 1'b0;
        @(negedge clk);

        // Crash on the tick while IDLE is ignored
        tick_with_crash();
        check("idle_crash_freeze", {31'd0, bus.freeze}, 32'd1);
        check("idle_crash_burn",   {31'd0, bus.burn},   32'd0);

        // Restart clears score; crash coincident with tick enters DYING at once
        press_start();
        check("restart_score",  {16'd0, bus.score},  32'd0);
        check("restart_freeze", {31'd0, bus.freeze}, 32'd0);
        tick_with_crash();
        check("coinc_burn",   {31'd0, bus.burn},   32'd1);
        check("coinc_freeze", {31'd0, bus.freeze}, 32'd1);

        // Reset mid-PLAYING with score 5
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        press_start();
        frames(152);
        check("pre_rst_score", {16'd0, bus.score},      32'd5);
        check("pre_rst_alt",   {31'd0, bus.alternator}, 32'd1);
        @(negedge clk);
        #5;
        rst = 1'b1;
        #2;
        check("async_freeze", {31'd0, bus.freeze},     32'd1);
        check("async_score",  {16'd0, bus.score},      32'd0);
        check("async_alt",    {31'd0, bus.alternator}, 32'd0);
        check("async_burn",   {31'd0, bus.burn},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Score saturation from a preloaded 16'hFFFE
        press_start();
        @(negedge clk);
        force dut.score_q = 16'hFFFE;
        @(negedge clk);
        release dut.score_q;
        frames(30);
        check("sat_first",  {16'd0, bus.score}, 32'h0000FFFF);
        frames(30);
        check("sat_hold",   {16'd0, bus.score}, 32'h0000FFFF);

        // One frame_tick per vsync rising edge, each exactly one cycle wide
        check("tick_count",  tick_cnt, rise_cnt);
        check("tick_single", dbl_cnt,  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Frame-rate game controller. It consumes the per-pixel `crash` flag from the colour mapper and turns it into game state. It also drives the colour mapper's sprite-select inputs: `alternator` for the wing-flap frame and `burn` for the burning sprite. It sits between the VGA timing and keyboard inputs on one side and the colour mapper, bird and obstacle motion blocks on the other. It freezes motion on a crash and keeps a survival score.

## Interface
Parameters:
- FLAP_FRAMES, 8: frame ticks between `alternator` toggles.
- BURN_FRAMES, 60: frame ticks spent in DYING before OVER.
- SCORE_FRAMES, 30: frame ticks per score increment while PLAYING.

Ports:
- Clk  in  1  system clock (50 MHz); single clock domain.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  VGA vertical sync. It is asynchronous to Clk and is synchronised internally.
- crash  in  1  per-pixel collision flag from the colour mapper, synchronous to Clk.
- start_key  in  1  level; high while the start key (space) is held; synchronous to Clk.
- alternator  out  1  wing-flap sprite select to the colour mapper.
- burn  out  1  burning-sprite select to the colour mapper.
- freeze  out  1  high while the bird and obstacle positions must hold.
- game_over  out  1  high in OVER.
- score  out  16  unsigned survival score.
- frame_tick  out  1  one-cycle pulse per frame, for downstream motion blocks.

## Operation
- States: IDLE, PLAYING, DYING, OVER.
- IDLE → PLAYING on a start press (rising edge of `start_key`); `score` clears to 0 on the same edge.
- PLAYING → DYING on a `frame_tick` if `crash_pending` = 1.
- DYING → OVER on the `frame_tick` that brings the burn counter to BURN_FRAMES.
- OVER → IDLE on a start press.
- A start press in PLAYING or DYING is ignored.
- `crash_pending`:
  - Sets on any cycle with `crash`=1 while in PLAYING.
  - Clears on every `frame_tick`.
  - A crash in the same cycle as `frame_tick` counts for that tick: the decision uses `crash_pending | crash`.
  - `crash` outside PLAYING is ignored.
- Flap counter:
  - Counts frame ticks in IDLE and PLAYING.
  - At FLAP_FRAMES−1 it wraps to 0 and toggles `alternator`.
  - It holds, and `alternator` holds, in DYING and OVER.
- Burn counter: clears on entry to DYING and increments per `frame_tick` in DYING.
- Score:
  - Divider counts frame ticks in PLAYING; at SCORE_FRAMES−1 it wraps and `score` increments.
  - `score` saturates at 16'hFFFF.
  - `score` holds in all other states until the next IDLE→PLAYING.
- Output decode from state:
  - `burn` = DYING or OVER.
  - `freeze` = IDLE, DYING or OVER.
  - `game_over` = OVER.

## Timing
- Reset (async, immediate): state IDLE; `alternator`=0, `burn`=0, `freeze`=1, `game_over`=0, `score`=0, `frame_tick`=0; all counters and `crash_pending` = 0.
- Reset mid-operation in any state returns to IDLE within the same cycle. No score or crash survives it.
- `frame_clk` path:
  - Two-flop synchroniser, then an edge register.
  - `frame_tick` pulses exactly one Clk cycle, 3 cycles after a `frame_clk` rising edge.
- Start press is detected one cycle after `start_key` rises; the state changes on the following edge.
- All state, counter and output updates are registered on the `frame_tick` cycle and become visible the next cycle.
- The decoded outputs follow the state register with no extra latency.
- A held `start_key` produces a single press. A new press requires `start_key` to go low for at least one cycle.

## Structure
- Package `game_pkg` holds:
  - the state enum (IDLE, PLAYING, DYING, OVER);
  - the default FLAP/BURN/SCORE constants;
  - the score width.
- Sub-module `frame_sync`: synchroniser plus rising-edge pulse generator for `frame_clk`. It is reusable by the motion blocks.
- The start-key edge detector stays inline.

## Test plan
- Reset: assert Reset mid-PLAYING with `score`=5 → immediately IDLE, `score`=0, `freeze`=1, `alternator`=0.
- Start and score (SCORE_FRAMES=30):
  - Start press in IDLE → PLAYING, `freeze`=0.
  - After 90 frame ticks with no crash → `score`=3.
  - `alternator` has toggled 11 times (90/8, FLAP_FRAMES=8).
- Crash latch: one-cycle `crash` pulse mid-frame in PLAYING → DYING after the next `frame_tick`; `burn`=1, `freeze`=1, `score` frozen.
- Crash coincident with `frame_tick` → DYING on that tick. The same pulse while in IDLE → state stays IDLE.
- Burn timing (BURN_FRAMES=60): 60 frame ticks after entering DYING → OVER, `game_over`=1, `burn` still 1. Then a start press → IDLE, `burn`=0.
- Edge cases:
  - `start_key` held high across OVER→IDLE → no auto-start into PLAYING.
  - `score` preloaded at 16'hFFFE → saturates at 16'hFFFF.
  - `frame_clk` toggled asynchronously → exactly one `frame_tick` per rising edge.
